bf16_fpu_cmp: RTL and testbench
===============================

Name: bf16_fpu_cmp

Overview:
- Single-cycle-issue, 1-cycle-latency bfloat16 (1/8/7) FPU slice for the Caravel user project area.
- Executes the RISC-V-F-style non-arithmetic ops: compare (FEQ/FLT/FLE), FMIN/FMAX, sign injection, FCLASS and FMV.
- Driven by the wishbone/CPU front-end.
- Results are registered and presented on a 16-bit bus that is routed to user GPIOs [23:8].

Parameters:
- CANON_NAN, 16'h7FC0, canonical quiet NaN returned by FMIN/FMAX when both operands are NaN.

Ports:
- wb_clk_i  input  1  clock; all state updates on the rising edge.
- wb_rst_i  input  1  reset; asynchronous, active-high.
- valid_i  input  1  operation request, sampled on the rising clock edge.
- op_i  input  4  opcode: 0 FEQ, 1 FLT, 2 FLE, 3 FMIN, 4 FMAX, 5 FSGNJ, 6 FSGNJN, 7 FSGNJX, 8 FCLASS, 9 FMV; 10-15 illegal.
- a_i  input  16  operand A (bf16).
- b_i  input  16  operand B (bf16).
- result_o  output  16  registered result.
- valid_o  output  1  result strobe.
- fflags_o  output  5  {NV,DZ,OF,UF,NX}, registered alongside result_o.
- illegal_o  output  1  opcode-illegal strobe.

Behaviour:
- Reset state: result_o=0, valid_o=0, fflags_o=0, illegal_o=0. Reset acts immediately and overrides any in-flight op; the first result after reset release needs a fresh valid_i.
- Latency:
  - valid_i high at edge N gives valid_o high after edge N+1 for exactly one cycle per request.
  - Back-to-back requests every cycle are supported.
  - result_o and fflags_o hold their last values while valid_i is low; valid_o is low then.
- Decode:
  - NaN: exp==8'hFF and mant!=0.
  - sNaN: NaN with mant[6]==0. qNaN: NaN with mant[6]==1.
  - Inf: exp==FF, mant==0. Zero: exp==0, mant==0. Subnormal: exp==0, mant!=0.
- Ordering:
  - Sign-magnitude compare; +0 and -0 are equal for FEQ/FLT/FLE.
  - Subnormals compare by magnitude; there is no flush to zero.
- FEQ: result 16'h0001 if equal, else 0. Any NaN gives 0. NV set only if either operand is an sNaN.
- FLT / FLE: result 16'h0001 if a<b (a<=b), else 0. Any NaN gives 0 and NV=1 (signaling compare).
- FMIN / FMAX:
  - Result is the smaller/larger operand, with -0 ordered below +0 (FMIN(+0,-0)=8000, FMAX=0000).
  - One operand NaN: return the other operand.
  - Both NaN: return CANON_NAN.
  - NV=1 if either operand is an sNaN.
- Sign injection (result = {s, a[14:0]}):
  - FSGNJ: s = b[15].
  - FSGNJN: s = ~b[15].
  - FSGNJX: s = a[15]^b[15].
  - No flags; NaN payloads pass untouched.
- FCLASS: result is a 10-bit one-hot in [9:0], [15:10]=0.
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0.
  - bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf.
  - bit8 sNaN, bit9 qNaN.
  - No flags.
- FMV: result = a_i, no flags.
- Illegal op (10-15): result 0, fflags 0, illegal_o=1 with valid_o.
- DZ, OF, UF and NX are always 0 in this block.

Test Plan:
- Reset: assert wb_rst_i mid-request (valid_i=1) -> outputs 0 immediately, no valid_o after release until a new request.
- Compares:
  - FLT 3F80,4000 -> 0001.
  - FLE 4000,4000 -> 0001.
  - FEQ 0000,8000 -> 0001.
  - FLT 7FC0,3F80 -> 0000, NV=1.
  - FEQ 7FC0,3F80 -> 0000, NV=0.
  - FEQ 7F81,3F80 -> NV=1.
- Min/max:
  - FMIN 449A,491E -> 449A.
  - FMAX 449A,491E -> 491E.
  - FMIN DC87,59EE -> DC87.
  - FMIN 0000,8000 -> 8000.
  - FMAX 7FC0,3042 -> 3042, NV=0.
  - FMAX 7F81,3F80 -> 3F80, NV=1.
  - FMIN 7FC0,7F81 -> 7FC0, NV=1.
- Sign injection / move:
  - FSGNJ 3042,8000 -> B042.
  - FSGNJN BCF0,8000 -> 3CF0.
  - FSGNJX BCF0,8000 -> 3CF0.
  - FMV 5CB0 -> 5CB0.
- FCLASS:
  - 3F80 -> 0040; BF80 -> 0002; FF80 -> 0001; 0001 -> 0020; 8000 -> 0008; 7F81 -> 0100; 7FC0 -> 0200.
- Throughput / illegal:
  - Ten consecutive-cycle requests -> ten consecutive valid_o pulses in order.
  - op 15 -> result 0, illegal_o=1.

Source files
------------

// File: rtl/bf16_fpu_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_fpu_cmp
//  Description : bfloat16 (1/8/7) non-arithmetic FPU slice. Executes
//                FEQ/FLT/FLE, FMIN/FMAX, FSGNJ/FSGNJN/FSGNJX, FCLASS and FMV.
//                Requests are captured on the edge that samples valid_i and
//                the result is registered on the following edge.
//  Ports       : wb_clk_i   - clock, rising edge
//                wb_rst_i   - asynchronous active-high reset
//                valid_i    - request strobe
//                op_i[3:0]  - opcode (0..9 legal, 10..15 illegal)
//                a_i, b_i   - bf16 operands
//                result_o   - registered 16-bit result (holds when idle)
//                valid_o    - one-cycle result strobe
//                fflags_o   - {NV,DZ,OF,UF,NX}; only NV can be set here
//                illegal_o  - illegal-opcode strobe, coincident with valid_o
//  Revision    : 1.0 - initial release
// ============================================================================
module bf16_fpu_cmp #(
   parameter logic [15:0] CANON_NAN = 16'h7FC0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        valid_i,
   input  logic [3:0]  op_i,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] result_o,
   output logic        valid_o,
   output logic [4:0]  fflags_o,
   output logic        illegal_o
);

   localparam logic [3:0] c_OP_FEQ    = 4'd0;
   localparam logic [3:0] c_OP_FLT    = 4'd1;
   localparam logic [3:0] c_OP_FLE    = 4'd2;
   localparam logic [3:0] c_OP_FMIN   = 4'd3;
   localparam logic [3:0] c_OP_FMAX   = 4'd4;
   localparam logic [3:0] c_OP_FSGNJ  = 4'd5;
   localparam logic [3:0] c_OP_FSGNJN = 4'd6;
   localparam logic [3:0] c_OP_FSGNJX = 4'd7;
   localparam logic [3:0] c_OP_FCLASS = 4'd8;
   localparam logic [3:0] c_OP_FMV    = 4'd9;

   // Sign-magnitude "x < y" for non-NaN operands; +0 and -0 compare equal.
   function automatic logic f_lt(input logic [15:0] x, input logic [15:0] y);
      logic r;
      if ((x[14:0] == 15'd0) && (y[14:0] == 15'd0)) r = 1'b0;
      else if (x[15] != y[15])                      r = x[15];
      else if (!x[15])                              r = (x[14:0] < y[14:0]);
      else                                          r = (x[14:0] > y[14:0]);
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Request capture stage
   // ------------------------------------------------------------------------
   logic        r_req_vld;
   logic [3:0]  r_op;
   logic [15:0] r_a;
   logic [15:0] r_b;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_req_vld <= 1'b0;
         r_op      <= 4'd0;
         r_a       <= 16'd0;
         r_b       <= 16'd0;
      end else begin
         r_req_vld <= valid_i;
         if (valid_i) begin
            r_op <= op_i;
            r_a  <= a_i;
            r_b  <= b_i;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Operand decode
   // ------------------------------------------------------------------------
   logic w_a_exp_ff, w_a_exp_0, w_a_man_0;
   logic w_b_exp_ff, w_b_man_0;
   logic w_a_nan, w_b_nan, w_a_snan, w_b_snan;
   logic w_any_nan, w_any_snan, w_both_zero;
   logic w_a_lt_b, w_b_lt_a, w_eq;
   logic w_min_is_a, w_max_is_a;

   assign w_a_exp_ff  = &r_a[14:7];
   assign w_a_exp_0   = ~|r_a[14:7];
   assign w_a_man_0   = ~|r_a[6:0];
   assign w_b_exp_ff  = &r_b[14:7];
   assign w_b_man_0   = ~|r_b[6:0];

   assign w_a_nan     = w_a_exp_ff & ~w_a_man_0;
   assign w_b_nan     = w_b_exp_ff & ~w_b_man_0;
   assign w_a_snan    = w_a_nan & ~r_a[6];
   assign w_b_snan    = w_b_nan & ~r_b[6];
   assign w_any_nan   = w_a_nan | w_b_nan;
   assign w_any_snan  = w_a_snan | w_b_snan;
   assign w_both_zero = (r_a[14:0] == 15'd0) && (r_b[14:0] == 15'd0);

   assign w_a_lt_b    = f_lt(r_a, r_b);
   assign w_b_lt_a    = f_lt(r_b, r_a);
   assign w_eq        = w_both_zero || (r_a == r_b);

   // For min/max the zeros are ordered -0 < +0, so a signed-zero pair is
   // resolved by the sign of A. Equal non-zero operands are bit-identical.
   assign w_min_is_a  = w_a_lt_b | (w_both_zero & r_a[15]);
   assign w_max_is_a  = w_b_lt_a | (w_both_zero & ~r_a[15]);

   // ------------------------------------------------------------------------
   // Operation select
   // ------------------------------------------------------------------------
   logic [15:0] w_res;
   logic        w_nv;
   logic        w_ill;
   logic [9:0]  w_class;

   always_comb begin
      w_class = 10'd0;
      if (w_a_exp_ff) begin
         if (w_a_man_0)     w_class = r_a[15] ? 10'h001 : 10'h080;
         else if (r_a[6])   w_class = 10'h200;
         else               w_class = 10'h100;
      end else if (w_a_exp_0) begin
         if (w_a_man_0)     w_class = r_a[15] ? 10'h008 : 10'h010;
         else               w_class = r_a[15] ? 10'h004 : 10'h020;
      end else begin
         w_class = r_a[15] ? 10'h002 : 10'h040;
      end
   end

   always_comb begin
      w_res = 16'd0;
      w_nv  = 1'b0;
      w_ill = 1'b0;
      case (r_op)
         c_OP_FEQ: begin
            w_res = {15'd0, ~w_any_nan & w_eq};
            w_nv  = w_any_snan;
         end
         c_OP_FLT: begin
            w_res = {15'd0, ~w_any_nan & w_a_lt_b};
            w_nv  = w_any_nan;
         end
         c_OP_FLE: begin
            w_res = {15'd0, ~w_any_nan & (w_a_lt_b | w_eq)};
            w_nv  = w_any_nan;
         end
         c_OP_FMIN, c_OP_FMAX: begin
            if (w_a_nan && w_b_nan)  w_res = CANON_NAN;
            else if (w_a_nan)        w_res = r_b;
            else if (w_b_nan)        w_res = r_a;
            else if (r_op == c_OP_FMIN) w_res = w_min_is_a ? r_a : r_b;
            else                     w_res = w_max_is_a ? r_a : r_b;
            w_nv = w_any_snan;
         end
         c_OP_FSGNJ:  w_res = {r_b[15], r_a[14:0]};
         c_OP_FSGNJN: w_res = {~r_b[15], r_a[14:0]};
         c_OP_FSGNJX: w_res = {r_a[15] ^ r_b[15], r_a[14:0]};
         c_OP_FCLASS: w_res = {6'd0, w_class};
         c_OP_FMV:    w_res = r_a;
         default:     w_ill = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------------
   // Result stage: result/flags hold between requests, strobes pulse once.
   // ------------------------------------------------------------------------
   logic [15:0] r_result;
   logic        r_valid;
   logic [4:0]  r_fflags;
   logic        r_illegal;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_result  <= 16'd0;
         r_valid   <= 1'b0;
         r_fflags  <= 5'd0;
         r_illegal <= 1'b0;
      end else begin
         r_valid   <= r_req_vld;
         r_illegal <= r_req_vld & w_ill;
         if (r_req_vld) begin
            r_result <= w_res;
            r_fflags <= {w_nv, 4'd0};
         end
      end
   end

   assign result_o  = r_result;
   assign valid_o   = r_valid;
   assign fflags_o  = r_fflags;
   assign illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_bf16_fpu_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bf16_fpu_cmp
//  Description : Scoreboard bench for bf16_fpu_cmp. Directed vectors carry
//                literal expected values; random vectors use a value-key
//                reference model. Expected entries are queued at drive time
//                and compared when valid_o is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bf16_fpu_cmp;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic        valid_i;
   logic [3:0]  op_i;
   logic [15:0] a_i;
   logic [15:0] b_i;
   logic [15:0] result_o;
   logic        valid_o;
   logic [4:0]  fflags_o;
   logic        illegal_o;

   bf16_fpu_cmp #(.CANON_NAN(16'h7FC0)) u_dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .valid_i   (valid_i),
      .op_i      (op_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .result_o  (result_o),
      .valid_o   (valid_o),
      .fflags_o  (fflags_o),
      .illegal_o (illegal_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      logic [15:0] res;
      logic [4:0]  flg;
      logic        ill;
      int          stamp;
      logic [3:0]  op;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cyc     = 0;

   always @(posedge wb_clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // Reference model: map each non-NaN value onto a signed integer key so
   // that ordering and +0/-0 equality fall out of plain integer compares.
   function automatic int key(input logic [15:0] x);
      int m;
      m = int'(x[14:0]);
      return x[15] ? -m : m;
   endfunction

   function automatic logic is_nan(input logic [15:0] x);
      return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
   endfunction

   function automatic logic is_snan(input logic [15:0] x);
      return is_nan(x) && !x[6];
   endfunction

   task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic nv, output logic ill);
      logic an, bn;
      an = is_nan(a);
      bn = is_nan(b);
      r = 16'd0; nv = 1'b0; ill = 1'b0;
      case (op)
         4'd0: begin r = (!an && !bn && key(a) == key(b)) ? 16'd1 : 16'd0; nv = is_snan(a) || is_snan(b); end
         4'd1: begin r = (!an && !bn && key(a) <  key(b)) ? 16'd1 : 16'd0; nv = an || bn; end
         4'd2: begin r = (!an && !bn && key(a) <= key(b)) ? 16'd1 : 16'd0; nv = an || bn; end
         4'd3, 4'd4: begin
            nv = is_snan(a) || is_snan(b);
            if (an && bn)               r = 16'h7FC0;
            else if (an)                r = b;
            else if (bn)                r = a;
            else if (key(a) < key(b))   r = (op == 4'd3) ? a : b;
            else if (key(b) < key(a))   r = (op == 4'd3) ? b : a;
            else if (op == 4'd3)        r = a[15] ? a : b;
            else                        r = a[15] ? b : a;
         end
         4'd5: r = {b[15], a[14:0]};
         4'd6: r = {!b[15], a[14:0]};
         4'd7: r = {a[15] ^ b[15], a[14:0]};
         4'd8: begin
            if (a[14:7] == 8'hFF) begin
               if (a[6:0] == 7'd0) r = a[15] ? 16'h0001 : 16'h0080;
               else                r = a[6] ? 16'h0200 : 16'h0100;
            end else if (a[14:7] == 8'h00) begin
               if (a[6:0] == 7'd0) r = a[15] ? 16'h0008 : 16'h0010;
               else                r = a[15] ? 16'h0004 : 16'h0020;
            end else begin
               r = a[15] ? 16'h0002 : 16'h0040;
            end
         end
         4'd9: r = a;
         default: ill = 1'b1;
      endcase
   endtask

   // Drive one request at the falling edge and queue its expectation.
   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic env, input logic eill);
      exp_t e;
      valid_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      e.res   = er;
      e.flg   = {env, 4'd0};
      e.ill   = eill;
      e.stamp = cyc + 1;
      e.op    = op;
      sb.push_back(e);
      @(negedge wb_clk_i);
   endtask

   task automatic idle_drain();
      valid_i = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge wb_clk_i);
      check("drain_outstanding", sb.size(), 0);
   endtask

   // Output monitor
   always @(negedge wb_clk_i) begin
      if (!wb_rst_i) begin
         if (valid_o) begin
            if (sb.size() == 0) begin
               check("spurious_valid", 32'(valid_o), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check($sformatf("result op%0d", e.op), 32'(result_o), 32'(e.res));
               check($sformatf("fflags op%0d", e.op), 32'(fflags_o), 32'(e.flg));
               check($sformatf("illegal op%0d", e.op), 32'(illegal_o), 32'(e.ill));
               check("latency", 32'(cyc - e.stamp), 32'd1);
            end
         end else begin
            check("illegal_without_valid", 32'(illegal_o), 32'd0);
         end
      end
   end

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        nv;
      logic        ill;
   } vec_t;

   vec_t dir[$] = '{
      '{4'd1, 16'h3F80, 16'h4000, 16'h0001, 1'b0, 1'b0},
      '{4'd2, 16'h4000, 16'h4000, 16'h0001, 1'b0, 1'b0},
      '{4'd0, 16'h0000, 16'h8000, 16'h0001, 1'b0, 1'b0},
      '{4'd1, 16'h7FC0, 16'h3F80, 16'h0000, 1'b1, 1'b0},
      '{4'd0, 16'h7FC0, 16'h3F80, 16'h0000, 1'b0, 1'b0},
      '{4'd0, 16'h7F81, 16'h3F80, 16'h0000, 1'b1, 1'b0},
      '{4'd3, 16'h449A, 16'h491E, 16'h449A, 1'b0, 1'b0},
      '{4'd4, 16'h449A, 16'h491E, 16'h491E, 1'b0, 1'b0},
      '{4'd3, 16'hDC87, 16'h59EE, 16'hDC87, 1'b0, 1'b0},
      '{4'd3, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b0},
      '{4'd4, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0},
      '{4'd4, 16'h7FC0, 16'h3042, 16'h3042, 1'b0, 1'b0},
      '{4'd4, 16'h7F81, 16'h3F80, 16'h3F80, 1'b1, 1'b0},
      '{4'd3, 16'h7FC0, 16'h7F81, 16'h7FC0, 1'b1, 1'b0},
      '{4'd5, 16'h3042, 16'h8000, 16'hB042, 1'b0, 1'b0},
      '{4'd6, 16'hBCF0, 16'h8000, 16'h3CF0, 1'b0, 1'b0},
      '{4'd7, 16'hBCF0, 16'h8000, 16'h3CF0, 1'b0, 1'b0},
      '{4'd9, 16'h5CB0, 16'h0000, 16'h5CB0, 1'b0, 1'b0},
      '{4'd8, 16'h3F80, 16'h0000, 16'h0040, 1'b0, 1'b0},
      '{4'd8, 16'hBF80, 16'h0000, 16'h0002, 1'b0, 1'b0},
      '{4'd8, 16'hFF80, 16'h0000, 16'h0001, 1'b0, 1'b0},
      '{4'd8, 16'h0001, 16'h0000, 16'h0020, 1'b0, 1'b0},
      '{4'd8, 16'h8000, 16'h0000, 16'h0008, 1'b0, 1'b0},
      '{4'd8, 16'h7F81, 16'h0000, 16'h0100, 1'b0, 1'b0},
      '{4'd8, 16'h7FC0, 16'h0000, 16'h0200, 1'b0, 1'b0},
      '{4'd15, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1}
   };

   logic [15:0] pool [12] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h7F81,
                              16'hFFA0, 16'h0001, 16'h8001, 16'h3F80, 16'hBF80, 16'h4000};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0]  op;
      logic [15:0] a, b, r;
      logic        nv, ill;

      wb_rst_i = 1'b1;
      valid_i  = 1'b0;
      op_i     = 4'd0;
      a_i      = 16'd0;
      b_i      = 16'd0;
      repeat (2) @(negedge wb_clk_i);
      check("reset result_o",  32'(result_o),  32'd0);
      check("reset valid_o",   32'(valid_o),   32'd0);
      check("reset fflags_o",  32'(fflags_o),  32'd0);
      check("reset illegal_o", 32'(illegal_o), 32'd0);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);

      // Directed vectors issued back-to-back (also covers throughput).
      foreach (dir[i]) send(dir[i].op, dir[i].a, dir[i].b, dir[i].r, dir[i].nv, dir[i].ill);
      idle_drain();

      // Random vectors against the reference model.
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 11)] : 16'($urandom);
         b  = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 11)] : 16'($urandom);
         model(op, a, b, r, nv, ill);
         send(op, a, b, r, nv, ill);
         if ($urandom_range(0, 3) == 0) begin
            valid_i = 1'b0;
            @(negedge wb_clk_i);
         end
      end
      idle_drain();

      // Leave a non-zero result held, then reset with a request in flight.
      send(4'd9, 16'h5CB0, 16'h0000, 16'h5CB0, 1'b0, 1'b0);
      idle_drain();
      check("hold result_o", 32'(result_o), 32'h5CB0);
      valid_i = 1'b1;
      op_i    = 4'd9;
      a_i     = 16'h1234;
      @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b1;
      #1;
      check("midreset result_o",  32'(result_o),  32'd0);
      check("midreset valid_o",   32'(valid_o),   32'd0);
      check("midreset fflags_o",  32'(fflags_o),  32'd0);
      check("midreset illegal_o", 32'(illegal_o), 32'd0);
      @(negedge wb_clk_i);
      valid_i  = 1'b0;
      wb_rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge wb_clk_i);
         check("post_reset no valid_o", 32'(valid_o), 32'd0);
      end
      send(4'd9, 16'h4321, 16'h0000, 16'h4321, 1'b0, 1'b0);
      idle_drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
